// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge
// Breaks one cache-line read or write from the data cache into BUS_WIDTH-wide
// single-beat transactions on a valid/ready memory bus. One line transaction
// is in flight at a time. Completion is signalled by a one-cycle done pulse.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   memAddr            line address (offset bits ignored)
//   memReadEnable      line read request (level, wins over write)
//   memWriteEnable     line write request (level)
//   memWriteValue      line to write, byte 0 in [7:0]
//   memReadDone        one-cycle pulse, read line complete
//   memWriteDone       one-cycle pulse, write line complete
//   memReadValue       assembled read line, held until next read's first beat
//   busReq*            beat request channel (valid/ready)
//   busResp*           beat response channel (read data or write ack)
module dcache_mem_bridge #(
  parameter int LINE_SIZE  = 8,
  parameter int LINE_WIDTH = LINE_SIZE*8,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_COUNT = LINE_WIDTH/BUS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memReadEnable,
  input  logic                  memWriteEnable,
  input  logic [LINE_WIDTH-1:0] memWriteValue,
  output logic                  memReadDone,
  output logic                  memWriteDone,
  output logic [LINE_WIDTH-1:0] memReadValue,
  output logic                  busReqValid,
  input  logic                  busReqReady,
  output logic                  busReqWrite,
  output logic [ADDR_WIDTH-1:0] busReqAddr,
  output logic [BUS_WIDTH-1:0]  busReqData,
  input  logic                  busRespValid,
  input  logic [BUS_WIDTH-1:0]  busRespData
);

  localparam int BEAT_W  = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam int BYTE_SH = $clog2(BUS_WIDTH/8);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEAT_COUNT-1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_SIZE-1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e                                state_q, state_d;
  logic                                  op_wr_q, op_wr_d;
  logic [BEAT_W-1:0]                     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]                 base_q, base_d;
  // Lines held as beat-indexed packed arrays so a beat is a plain index.
  logic [BEAT_COUNT-1:0][BUS_WIDTH-1:0]  wline_q, wline_d;
  logic [BEAT_COUNT-1:0][BUS_WIDTH-1:0]  rline_q, rline_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      beat_q  <= '0;
      base_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    beat_d       = beat_q;
    base_d       = base_q;
    wline_d      = wline_q;
    rline_d      = rline_q;
    busReqValid  = 1'b0;
    memReadDone  = 1'b0;
    memWriteDone = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memReadEnable) begin
          base_d  = memAddr & ~OFF_MASK;
          op_wr_d = 1'b0;
          beat_d  = '0;
          state_d = S_REQ;
        end else if (memWriteEnable) begin
          base_d  = memAddr & ~OFF_MASK;
          wline_d = memWriteValue;
          op_wr_d = 1'b1;
          beat_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Valid is decoded straight from the state register so an async
        // reset drops it without waiting for a clock edge.
        busReqValid = 1'b1;
        if (busReqReady) state_d = S_RESP;
      end
      S_RESP: begin
        if (busRespValid) begin
          if (!op_wr_q) rline_d[beat_q] = busRespData;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        memReadDone  = ~op_wr_q;
        memWriteDone = op_wr_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Base is line aligned, so OR-ing the beat offset never carries.
  assign busReqAddr   = base_q | (ADDR_WIDTH'(beat_q) << BYTE_SH);
  assign busReqWrite  = op_wr_q;
  assign busReqData   = wline_q[beat_q];
  assign memReadValue = rline_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Bench for dcache_mem_bridge: directed scenarios followed by randomized line
// transactions against a word-addressed memory model acting as the bus slave.
module tb_dcache_mem_bridge;
  localparam int LS = 8;
  localparam int LW = LS*8;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int BC = LW/BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] memAddr;
  logic          memReadEnable, memWriteEnable;
  logic [LW-1:0] memWriteValue;
  logic          memReadDone, memWriteDone;
  logic [LW-1:0] memReadValue;
  logic          busReqValid, busReqReady, busReqWrite;
  logic [AW-1:0] busReqAddr;
  logic [BW-1:0] busReqData;
  logic          busRespValid;
  logic [BW-1:0] busRespData;

  dcache_mem_bridge #(.LINE_SIZE(LS), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable), .memWriteValue(memWriteValue),
    .memReadDone(memReadDone), .memWriteDone(memWriteDone), .memReadValue(memReadValue),
    .busReqValid(busReqValid), .busReqReady(busReqReady), .busReqWrite(busReqWrite),
    .busReqAddr(busReqAddr), .busReqData(busReqData),
    .busRespValid(busRespValid), .busRespData(busRespData)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [logic [31:0]];
  logic [LW-1:0] last_rl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // One line transaction, called at a negedge with the DUT idle (fresh=1) or
  // already requesting (fresh=0). stall0>=0 forces the stall count of beat 0.
  // abort: 0 none, 1 reset while awaiting the last response, 2 reset while
  // beat 0 is being requested.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] wv, input int stall0, input int stall_max,
                         input int dly_max, input bit spur, input bit scr,
                         input bit keep, input bit fresh, input int abort);
    bit is_wr, done, aborted, seen, pend;
    int beat, stall, wait_c;
    logic [31:0] base;
    logic [31:0] ea [BC];
    logic [31:0] ed [BC];
    logic [LW-1:0] exp_line;
    is_wr = !rd && wr;
    base = addr & ~32'(LS-1);
    for (int b = 0; b < BC; b++) begin
      ea[b] = base + 32'(b*(BW/8));
      ed[b] = wv[b*BW +: BW];
      exp_line[b*BW +: BW] = mem_rd(ea[b]);
    end
    memAddr = addr; memWriteValue = wv; memReadEnable = rd; memWriteEnable = wr;
    done = 0; aborted = 0; seen = 0; pend = 0; beat = 0; wait_c = 0;
    stall = (stall0 >= 0) ? stall0 : $urandom_range(0, stall_max);
    for (int cyc = 0; cyc < 400; cyc++) begin
      busReqReady = 1'b0; busRespValid = 1'b0; busRespData = $urandom;
      if (cyc > 0 && !keep) begin memReadEnable = 1'b0; memWriteEnable = 1'b0; end
      if (cyc > 0 && scr) begin memAddr = $urandom; memWriteValue = {$urandom, $urandom}; end
      if (memReadDone || memWriteDone) begin
        chk("rd_done", memReadDone, !is_wr);
        chk("wr_done", memWriteDone, is_wr);
        chk("beats_before_done", beat, BC);
        if (!is_wr) begin chk("read_line", memReadValue, exp_line); last_rl = exp_line; end
        else chk("read_line_hold", memReadValue, last_rl);
        if (fresh && stall0 <= 0 && stall_max == 0 && dly_max == 0)
          chk("latency", cyc + 1, 2 + 2*BC);
        if (!keep) begin memReadEnable = 1'b0; memWriteEnable = 1'b0; end
        done = 1;
      end else if (busReqValid) begin
        chk("req_addr", busReqAddr, ea[beat]);
        chk("req_write", busReqWrite, is_wr);
        if (is_wr) chk("req_data", busReqData, ed[beat]);
        if (abort == 2 && cyc > 0) begin aborted = 1; done = 1; end
        else if (stall > 0) begin
          stall--;
          busRespValid = spur;
        end else begin
          busReqReady = 1'b1; busRespValid = spur;
          if (is_wr) mem[ea[beat]] = ed[beat];
          pend = 1; wait_c = $urandom_range(0, dly_max);
          stall = $urandom_range(0, stall_max);
        end
      end else if (pend) begin
        if (abort == 1 && beat == BC-1) begin aborted = 1; done = 1; end
        else if (wait_c == 0) begin
          busRespValid = 1'b1;
          busRespData = is_wr ? $urandom : mem_rd(ea[beat]);
          pend = 0; beat++;
        end else wait_c--;
      end
      if (aborted) break;
      @(negedge clk);
      if (done) break;
    end
    if (aborted) begin
      rst = 1'b0;
      #1;
      chk("abort_valid_drop", busReqValid, 1'b0);
      chk("abort_no_done", {memReadDone, memWriteDone}, 2'b00);
      busReqReady = 1'b0; busRespValid = 1'b0;
      memReadEnable = 1'b0; memWriteEnable = 1'b0;
      @(negedge clk);
      chk("abort_addr_zero", busReqAddr, 32'h0);
      chk("abort_rline_zero", memReadValue, 64'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_idle", {busReqValid, memReadDone, memWriteDone}, 3'b000);
      last_rl = '0;
    end else if (!done) begin
      chk("timeout", 1'b0, 1'b1);
    end else begin
      chk("single_pulse", {memReadDone, memWriteDone}, 2'b00);
      chk("idle_after_done", busReqValid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; memAddr = '0; memReadEnable = 0; memWriteEnable = 0; memWriteValue = '0;
    busReqReady = 0; busRespValid = 0; busRespData = '0; last_rl = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {memReadDone, memWriteDone, busReqValid, busReqWrite}, 4'b0000);
    chk("rst_addr", busReqAddr, 32'h0);
    chk("rst_data", busReqData, 32'h0);
    chk("rst_rline", memReadValue, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read at an unaligned address.
    mem[32'h1000] = 32'h1111_1111; mem[32'h1004] = 32'h2222_2222;
    run_txn(1, 0, 32'h0000_1004, '0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t1_line", memReadValue, 64'h2222_2222_1111_1111);

    // Write with beat 0 stalled, then read it back.
    run_txn(0, 1, 32'h2000, 64'hAABB_CCDD_0011_2233, 3, 0, 0, 0, 0, 0, 1, 0);
    run_txn(1, 0, 32'h2000, '0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t2_readback", memReadValue, 64'hAABB_CCDD_0011_2233);

    // Both enables: read wins.
    run_txn(1, 1, 32'h2000, 64'h0123_4567_89AB_CDEF, 0, 1, 1, 0, 0, 0, 1, 0);
    run_txn(1, 0, 32'h2000, '0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_no_write", memReadValue, 64'hAABB_CCDD_0011_2233);

    // Spurious responses in Request and a scrambled address mid-read.
    run_txn(1, 0, 32'h1000, '0, 2, 2, 2, 1, 1, 0, 1, 0);

    // Reset during the last response, then reset during a request.
    run_txn(1, 0, 32'h1000, '0, 0, 0, 2, 0, 0, 0, 1, 1);
    run_txn(1, 0, 32'h1000, '0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t5_fresh_line", memReadValue, 64'h2222_2222_1111_1111);
    run_txn(0, 1, 32'h4000, 64'h5555_6666_7777_8888, 2, 0, 0, 0, 0, 0, 1, 2);

    // Enable held across Done: back-to-back transactions.
    run_txn(1, 0, 32'h2000, '0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    chk("t6_restart", busReqValid, 1'b1);
    run_txn(1, 0, 32'h2000, '0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Address wrap at the top of the space.
    run_txn(1, 0, 32'hFFFF_FFFB, '0, 0, 1, 1, 0, 0, 0, 1, 0);

    // Randomized mix over a small address window so reads observe writes.
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = 32'h3000 + 32'($urandom_range(0, 7) << 3) + 32'($urandom_range(0, 7));
      run_txn(op != 1, op != 0, a, {$urandom, $urandom}, -1, $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              0, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
